// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: assembles little-endian words from a byte
// stream, writes them from address 0 upward and holds the core in reset until done.
//
// state | meaning
// IDLE  | waiting for a legal start; core reset reflects last completed load
// LOAD  | accepting bytes into the assembly register
// WRITE | one-cycle write strobe for the assembled word
// DONE  | one-cycle completion pulse; core reset released on exit
module imem_loader #(
  parameter int DEPTH = 256,
  parameter int CNT_W = 9
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic             byte_valid_i,
  input  logic [7:0]       byte_data_i,
  output logic             byte_ready_o,
  output logic             we_o,
  output logic [31:0]      waddr_o,
  output logic [31:0]      wdata_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             cpu_rst_no
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       bcnt_q, bcnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [31:0]      asm_q, asm_d;
  logic             ready_d, we_d, busy_d, done_d, err_d, cpu_rst_d;
  logic [31:0]      waddr_d, wdata_d;
  logic             xfer, len_ok, last_word;

  assign xfer      = byte_valid_i && byte_ready_o;
  assign len_ok    = (len_i != '0) && (len_i <= CNT_W'(DEPTH));
  assign last_word = (CNT_W'(idx_q) == (len_q - CNT_W'(1)));

  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    idx_d     = idx_q;
    len_d     = len_q;
    asm_d     = asm_q;
    we_d      = 1'b0;
    err_d     = 1'b0;
    waddr_d   = waddr_o;
    wdata_d   = wdata_o;
    cpu_rst_d = cpu_rst_no;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_ok) begin
            len_d     = len_i;
            bcnt_d    = 2'd0;
            idx_d     = '0;
            asm_d     = '0;
            cpu_rst_d = 1'b0;
            state_d   = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (xfer) begin
          asm_d[{bcnt_q, 3'b000} +: 8] = byte_data_i;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            // Write strobe is registered, so address/data are captured on this edge.
            state_d = WRITE;
            we_d    = 1'b1;
            waddr_d = 32'({idx_q, 2'b00});
            wdata_d = {byte_data_i, asm_q[23:0]};
          end
        end
      end
      WRITE: begin
        if (last_word) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = LOAD;
        end
      end
      DONE: begin
        state_d   = IDLE;
        cpu_rst_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == LOAD);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      bcnt_q       <= 2'd0;
      idx_q        <= '0;
      len_q        <= '0;
      asm_q        <= '0;
      byte_ready_o <= 1'b0;
      we_o         <= 1'b0;
      waddr_o      <= '0;
      wdata_o      <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      cpu_rst_no   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bcnt_q       <= bcnt_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      asm_q        <= asm_d;
      byte_ready_o <= ready_d;
      we_o         <= we_d;
      waddr_o      <= waddr_d;
      wdata_o      <= wdata_d;
      busy_o       <= busy_d;
      done_o       <= done_d;
      err_o        <= err_d;
      cpu_rst_no   <= cpu_rst_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: byte streams with random valid gaps,
// checked against a word-list model built from the stream itself.
module tb_imem_loader;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [8:0]  len_i = '0;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_data_i = '0;
  logic        byte_ready_o, we_o, busy_o, done_o, err_o, cpu_rst_no;
  logic [31:0] waddr_o, wdata_o;

  imem_loader #(.DEPTH(256), .CNT_W(9)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .len_i(len_i),
    .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i),
    .byte_ready_o(byte_ready_o), .we_o(we_o), .waddr_o(waddr_o),
    .wdata_o(wdata_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .cpu_rst_no(cpu_rst_no)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Bus monitor, sampled on the falling edge.
  int          cyc = 0, hs_cnt = 0, last4 = 0, last_we = 0;
  int          ready_cnt = 0, done_cnt = 0, err_cnt = 0;
  logic        done_prev = 1'b0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  always @(negedge clk_i) begin
    cyc++;
    if (done_prev && rst_ni) chk("cpu_rst_rise", {31'd0, cpu_rst_no}, 32'd1);
    done_prev = done_o;
    if (byte_ready_o) ready_cnt++;
    if (byte_valid_i && byte_ready_o) begin
      hs_cnt++;
      if (hs_cnt % 4 == 0) last4 = cyc;
    end
    if (we_o) begin
      wa_q.push_back(waddr_o);
      wd_q.push_back(wdata_o);
      chk("we_latency", 32'(cyc - last4), 32'd1);
      last_we = cyc;
    end
    if (done_o) begin
      done_cnt++;
      chk("done_latency", 32'(cyc - last_we), 32'd1);
    end
    if (err_o) err_cnt++;
  end

  logic [7:0] stim[$];
  bit         pat[7] = '{1, 0, 0, 1, 0, 1, 1};

  task automatic clear_mon();
    hs_cnt = 0; ready_cnt = 0; done_cnt = 0; err_cnt = 0;
    wa_q.delete(); wd_q.delete();
  endtask

  task automatic fill_rand(input int nbytes);
    stim.delete();
    for (int i = 0; i < nbytes; i++) stim.push_back(8'($urandom_range(0, 255)));
  endtask

  // mode 0: valid held high, 1: fixed gap pattern, 2: random valid.
  task automatic do_load(input int len, input int mode, input bit inj, input int abort_at);
    int   idx = 0, k = 0, budget = 0, w = 0;
    logic hs;
    logic [31:0] exp_d;
    clear_mon();
    @(posedge clk_i); #1 start_i = 1'b1; len_i = len[8:0];
    @(posedge clk_i); #1 start_i = 1'b0;
    chk("busy_after_start", {31'd0, busy_o}, 32'd1);
    chk("cpu_rst_low", {31'd0, cpu_rst_no}, 32'd0);
    while (idx < stim.size() && budget < 20000) begin
      if (abort_at >= 0 && idx == abort_at) break;
      case (mode)
        0:       byte_valid_i = 1'b1;
        1:       byte_valid_i = (k < 7) ? pat[k] : 1'b1;
        default: byte_valid_i = 1'($urandom_range(0, 1));
      endcase
      byte_data_i = stim[idx];
      if (inj && idx == 2) begin start_i = 1'b1; len_i = 9'd5; end
      else start_i = 1'b0;
      @(negedge clk_i);
      hs = byte_valid_i && byte_ready_o;
      @(posedge clk_i); #1;
      if (hs) idx++;
      k++; budget++;
    end
    byte_valid_i = 1'b0;
    start_i = 1'b0;
    if (budget >= 20000) chk("stream_timeout", 32'd0, 32'd1);
    if (abort_at >= 0) return;
    while (done_cnt == 0 && w < 20) begin @(negedge clk_i); w++; end
    chk("done_count", 32'(done_cnt), 32'd1);
    @(negedge clk_i); @(negedge clk_i);
    chk("cpu_rst_high", {31'd0, cpu_rst_no}, 32'd1);
    chk("busy_idle", {31'd0, busy_o}, 32'd0);
    chk("n_writes", 32'(wa_q.size()), 32'(len));
    chk("handshakes", 32'(hs_cnt), 32'(4 * len));
    chk("no_err", 32'(err_cnt), 32'd0);
    for (int j = 0; j < len && j < wa_q.size(); j++) begin
      exp_d = {stim[4*j+3], stim[4*j+2], stim[4*j+1], stim[4*j]};
      chk("waddr", wa_q[j], 32'(4 * j));
      chk("wdata", wd_q[j], exp_d);
    end
  endtask

  initial begin
    #2;
    chk("rst_ready", {31'd0, byte_ready_o}, 32'd0);
    chk("rst_we", {31'd0, we_o}, 32'd0);
    chk("rst_waddr", waddr_o, 32'd0);
    chk("rst_wdata", wdata_o, 32'd0);
    chk("rst_flags", {28'd0, busy_o, done_o, err_o, cpu_rst_no}, 32'd0);
    #20 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    chk("cpu_rst_after_release", {31'd0, cpu_rst_no}, 32'd0);

    // Directed single word, valid held high.
    stim.delete();
    stim.push_back(8'h33); stim.push_back(8'h82); stim.push_back(8'hB5); stim.push_back(8'h00);
    do_load(1, 0, 1'b0, -1);
    chk("ready_cycles", 32'(ready_cnt), 32'd4);
    chk("word0_literal", (wd_q.size() > 0) ? wd_q[0] : 32'hDEADBEEF, 32'h00B58233);

    // Three words of an incrementing stream.
    stim.delete();
    for (int i = 0; i < 12; i++) stim.push_back(8'(i));
    do_load(3, 0, 1'b0, -1);

    // Same single word with gaps on valid.
    stim.delete();
    stim.push_back(8'h33); stim.push_back(8'h82); stim.push_back(8'hB5); stim.push_back(8'h00);
    do_load(1, 1, 1'b0, -1);

    // Illegal lengths.
    clear_mon();
    @(posedge clk_i); #1 start_i = 1'b1; len_i = 9'd0;
    @(posedge clk_i); #1 start_i = 1'b0;
    chk("err_len0", {31'd0, err_o}, 32'd1);
    chk("busy_len0", {31'd0, busy_o}, 32'd0);
    @(posedge clk_i); #1 start_i = 1'b1; len_i = 9'd257;
    @(posedge clk_i); #1 start_i = 1'b0;
    chk("err_len257", {31'd0, err_o}, 32'd1);
    chk("busy_len257", {31'd0, busy_o}, 32'd0);
    @(negedge clk_i); @(negedge clk_i);
    chk("err_pulses", 32'(err_cnt), 32'd2);
    chk("err_no_we", 32'(wa_q.size()), 32'd0);
    chk("err_cpu_rst_kept", {31'd0, cpu_rst_no}, 32'd1);

    // Largest legal length.
    fill_rand(1024);
    do_load(256, 2, 1'b0, -1);

    // Start while loading is ignored.
    fill_rand(8);
    do_load(2, 0, 1'b1, -1);

    // Reset in the middle of the second word.
    fill_rand(8);
    do_load(2, 0, 1'b0, 6);
    rst_ni = 1'b0;
    #1;
    chk("abort_ready", {31'd0, byte_ready_o}, 32'd0);
    chk("abort_waddr", waddr_o, 32'd0);
    chk("abort_wdata", wdata_o, 32'd0);
    chk("abort_flags", {27'd0, we_o, busy_o, done_o, err_o, cpu_rst_no}, 32'd0);
    chk("abort_prior_writes", 32'(wa_q.size()), 32'd1);
    #3 rst_ni = 1'b1;
    fill_rand(4);
    do_load(1, 0, 1'b0, -1);

    // Random lengths and random valid gaps.
    for (int t = 0; t < 4; t++) begin
      int ln;
      ln = $urandom_range(1, 6);
      fill_rand(4 * ln);
      do_load(ln, 2, 1'b0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program writer for the 256-word instruction memory.
- Accepts a byte stream on a valid/ready handshake and assembles little-endian 32-bit words.
- Issues one-cycle write strobes at word-aligned byte addresses, starting at address 0.
- Holds the core in reset until a load completes, so fetch never sees a partially written program.

Parameters:
- DEPTH, 256, number of 32-bit words in the target instruction memory.
- CNT_W, 9, width of the word-count input; must hold the value DEPTH.

Ports:
- clk_i  input  1  clock, rising-edge.
- rst_ni  input  1  asynchronous active-low reset.
- start_i  input  1  single-cycle request to begin a load; sampled only in IDLE.
- len_i  input  CNT_W  number of words to load, valid range 1..DEPTH; sampled with start_i.
- byte_valid_i  input  1  byte_data_i is valid.
- byte_data_i  input  8  stream byte; first byte is the least-significant byte of a word.
- byte_ready_o  output  1  loader can accept a byte this cycle.
- we_o  output  1  imem write strobe, one cycle per word.
- waddr_o  output  32  byte address of the write, equal to word_idx<<2.
- wdata_o  output  32  assembled instruction word.
- busy_o  output  1  load in progress.
- done_o  output  1  one-cycle pulse when the final word has been written.
- err_o  output  1  one-cycle pulse on an illegal start.
- cpu_rst_no  output  1  active-low reset to the core; low until a load completes.

Behaviour:
- Reset values (asynchronous assert, synchronous release on clk_i):
  - state=IDLE; byte_ready_o=0, we_o=0, waddr_o=0, wdata_o=0.
  - busy_o=0, done_o=0, err_o=0, cpu_rst_no=0.
  - Internal byte counter = 0, word index = 0, word count = 0, assembly register = 0.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - If start_i=1 and 1<=len_i<=DEPTH: latch len_i, clear the byte counter and word index, drive cpu_rst_no=0, and go to LOAD.
  - If start_i=1 and (len_i==0 or len_i>DEPTH): err_o=1 for the next cycle, stay in IDLE, cpu_rst_no unchanged.
- LOAD:
  - byte_ready_o=1 and busy_o=1.
  - Transfer occurs when byte_valid_i && byte_ready_o. The byte is written to bits [8*k+7:8*k], where k is the byte counter (0..3), and the counter increments.
  - On the transfer with k==3: the counter wraps to 0 and the state goes to WRITE. No transfer occurs in a cycle where byte_valid_i=0; the state holds indefinitely.
- WRITE:
  - Lasts exactly one cycle.
  - Outputs: we_o=1, waddr_o=word_idx<<2, wdata_o=assembled word, byte_ready_o=0.
  - Next state: if word_idx==len-1, go to DONE; otherwise increment word_idx and go to LOAD.
- DONE:
  - Lasts one cycle: done_o=1, busy_o=1. cpu_rst_no goes to 1 on the next edge.
  - Then return to IDLE.
- Output timing: all outputs are registered. we_o never asserts outside WRITE. Byte-to-write latency is 1 cycle after the 4th byte handshake.
- start_i outside IDLE: ignored, no error.
- Back-to-back loads: a new start in IDLE after a completed load drops cpu_rst_no to 0 again and reloads from address 0.
- Reset mid-load: all state is discarded and cpu_rst_no=0. Partially written imem contents are left as-is; a new start is required.
- Byte offered while in WRITE or DONE: not accepted (byte_ready_o=0). The source must hold it until ready.

Test Plan:
- Reset, then start_i with len_i=1; stream bytes 0x33,0x82,0xB5,0x00 with valid held high → byte_ready_o is high for 4 cycles; one cycle later we_o=1, waddr_o=0x0, wdata_o=0x00B58233; next cycle done_o=1; next cycle cpu_rst_no=1.
- len_i=3 with 12 bytes 0x00..0x0B → writes 0x03020100@0x0, 0x07060504@0x4, 0x0B0A0908@0x8; exactly 3 we_o pulses; exactly 1 done_o pulse.
- Same as the first scenario with byte_valid_i toggled 1,0,0,1,0,1,1 → identical write result; no byte accepted while valid=0.
- start_i with len_i=0, then start_i with len_i=257 → err_o pulses twice, busy_o stays 0, no we_o; start_i with len_i=256 is accepted.
- rst_ni pulled low after 2 bytes of the second word of a len_i=2 load → all outputs return to reset values immediately; a new start with len_i=1 writes address 0x0 with a fresh word, not contaminated by stale bytes.
- start_i asserted while in LOAD → ignored, no err_o; the load finishes with its original length.
